// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encoding and
// the hard-wired zero register number.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR  = 2'd2
  } ctrl_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous active-low reset and synchronous clear.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_cnt <= {W{1'b0}};
    end else if (i_clr) begin
      r_cnt <= {W{1'b0}};
    end else if (i_inc && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + {{(W-1){1'b0}}, 1'b1};
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use bubbles, taken-branch
// squashes, data-memory wait freezes with timeout, and saturating event counters.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [4:0]       i_id_rs,
  input  logic [4:0]       i_id_rt,
  input  logic             i_id_uses_rs,
  input  logic             i_id_uses_rt,
  input  logic [4:0]       i_ex_rd,
  input  logic             i_ex_mem_read,
  input  logic             i_ex_branch_taken,
  input  logic             i_mem_req,
  input  logic             i_mem_ready,
  output logic             o_pc_we,
  output logic             o_ifid_hold,
  output logic             o_ifid_flush,
  output logic             o_idex_hold,
  output logic             o_idex_flush,
  output logic             o_exmem_hold,
  output logic             o_memwb_flush,
  output logic             o_mem_err,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt,
  output logic [CNT_W-1:0] o_wait_cnt
);

  localparam int WC_W = $clog2(MEM_TIMEOUT + 1);

  ctrl_state_e     r_state;
  ctrl_state_e     w_state_nxt;
  logic [WC_W-1:0] r_wait_cnt;
  logic [WC_W-1:0] w_wait_cnt_inc;
  logic            w_mem_stall;
  logic            w_freeze;
  logic            w_load_use;
  logic            w_branch_eff;
  logic            w_load_use_eff;
  logic            w_mem_wait_ev;

  assign w_mem_stall = i_mem_req & ~i_mem_ready;
  assign w_freeze    = w_mem_stall | (r_state == ST_ERR);
  assign w_load_use  = i_ex_mem_read & (i_ex_rd != REG_ZERO) &
                       ((i_id_uses_rs & (i_id_rs == i_ex_rd)) |
                        (i_id_uses_rt & (i_id_rt == i_ex_rd)));

  assign w_branch_eff   = ~w_freeze & i_ex_branch_taken;
  assign w_load_use_eff = ~w_freeze & ~i_ex_branch_taken & w_load_use;
  assign w_mem_wait_ev  = w_mem_stall & (r_state != ST_ERR);

  // The comparison sees the count including the current WAIT cycle, so the
  // RUN detection cycle plus MEM_TIMEOUT WAIT cycles are frozen before ERR.
  assign w_wait_cnt_inc = r_wait_cnt + WC_W'(1);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN: begin
        if (w_mem_stall) w_state_nxt = ST_WAIT;
        else             w_state_nxt = ST_RUN;
      end
      ST_WAIT: begin
        if (i_mem_ready)                               w_state_nxt = ST_RUN;
        else if (w_wait_cnt_inc == WC_W'(MEM_TIMEOUT)) w_state_nxt = ST_ERR;
        else                                           w_state_nxt = ST_WAIT;
      end
      ST_ERR:  w_state_nxt = ST_ERR;
      default: w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wait_cnt <= {WC_W{1'b0}};
    end else if ((r_state == ST_RUN) && (w_state_nxt == ST_WAIT)) begin
      r_wait_cnt <= {WC_W{1'b0}};
    end else if ((r_state == ST_WAIT) && !i_mem_ready) begin
      r_wait_cnt <= w_wait_cnt_inc;
    end
  end

  always_comb begin
    o_pc_we       = 1'b1;
    o_ifid_hold   = 1'b0;
    o_ifid_flush  = 1'b0;
    o_idex_hold   = 1'b0;
    o_idex_flush  = 1'b0;
    o_exmem_hold  = 1'b0;
    o_memwb_flush = 1'b0;
    if (!resetn) begin
      o_pc_we       = 1'b0;
      o_ifid_flush  = 1'b1;
      o_idex_flush  = 1'b1;
      o_memwb_flush = 1'b1;
    end else if (w_freeze) begin
      o_pc_we       = 1'b0;
      o_ifid_hold   = 1'b1;
      o_idex_hold   = 1'b1;
      o_exmem_hold  = 1'b1;
      o_memwb_flush = 1'b1;
    end else if (i_ex_branch_taken) begin
      o_ifid_flush  = 1'b1;
      o_idex_flush  = 1'b1;
    end else if (w_load_use) begin
      o_pc_we       = 1'b0;
      o_ifid_hold   = 1'b1;
      o_idex_flush  = 1'b1;
    end else begin
      o_pc_we       = 1'b1;
    end
  end

  assign o_mem_err = (r_state == ST_ERR);

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk    (clk),
    .resetn (resetn),
    .i_inc  (w_load_use_eff),
    .i_clr  (1'b0),
    .o_cnt  (o_stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk    (clk),
    .resetn (resetn),
    .i_inc  (w_branch_eff),
    .i_clr  (1'b0),
    .o_cnt  (o_flush_cnt)
  );

  sat_counter #(.W(CNT_W)) u_wait_cnt (
    .clk    (clk),
    .resetn (resetn),
    .i_inc  (w_mem_wait_ev),
    .i_clr  (1'b0),
    .o_cnt  (o_wait_cnt)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed testbench for pipe_hazard_ctrl (MEM_TIMEOUT=4, CNT_W=4).
module tb_pipe_hazard_ctrl;

  localparam int CW = 4;

  // Control vector order: pc_we, ifid_hold, ifid_flush, idex_hold, idex_flush, exmem_hold, memwb_flush
  localparam logic [6:0] C_NORMAL = 7'b1000000;
  localparam logic [6:0] C_FREEZE = 7'b0101011;
  localparam logic [6:0] C_BRANCH = 7'b1010100;
  localparam logic [6:0] C_LDUSE  = 7'b0100100;
  localparam logic [6:0] C_RESET  = 7'b0010101;

  logic          clk = 1'b0;
  logic          resetn;
  logic [4:0]    id_rs, id_rt, ex_rd;
  logic          id_uses_rs, id_uses_rt, ex_mem_read, ex_branch_taken;
  logic          mem_req, mem_ready;
  logic          pc_we, ifid_hold, ifid_flush, idex_hold, idex_flush, exmem_hold, memwb_flush;
  logic          mem_err;
  logic [CW-1:0] stall_cnt, flush_cnt, wait_cnt;
  logic [6:0]    ctl;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign ctl = {pc_we, ifid_hold, ifid_flush, idex_hold, idex_flush, exmem_hold, memwb_flush};

  pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CW)) dut (
    .clk               (clk),
    .resetn            (resetn),
    .i_id_rs           (id_rs),
    .i_id_rt           (id_rt),
    .i_id_uses_rs      (id_uses_rs),
    .i_id_uses_rt      (id_uses_rt),
    .i_ex_rd           (ex_rd),
    .i_ex_mem_read     (ex_mem_read),
    .i_ex_branch_taken (ex_branch_taken),
    .i_mem_req         (mem_req),
    .i_mem_ready       (mem_ready),
    .o_pc_we           (pc_we),
    .o_ifid_hold       (ifid_hold),
    .o_ifid_flush      (ifid_flush),
    .o_idex_hold       (idex_hold),
    .o_idex_flush      (idex_flush),
    .o_exmem_hold      (exmem_hold),
    .o_memwb_flush     (memwb_flush),
    .o_mem_err         (mem_err),
    .o_stall_cnt       (stall_cnt),
    .o_flush_cnt       (flush_cnt),
    .o_wait_cnt        (wait_cnt)
  );

  task automatic idle();
    id_rs = 5'd0; id_rt = 5'd0; ex_rd = 5'd0;
    id_uses_rs = 1'b0; id_uses_rt = 1'b0;
    ex_mem_read = 1'b0; ex_branch_taken = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_hazard(input logic [4:0] rd);
    ex_mem_read = 1'b1; ex_rd = rd; id_rs = 5'd5; id_uses_rs = 1'b1;
  endtask

  task automatic do_reset();
    idle();
    resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    idle();
    resetn = 1'b0;
    #1;
    checks++;
    if (ctl !== C_RESET) begin errors++; $display("FAIL reset_ctl got=%b exp=%b", ctl, C_RESET); end
    tick();
    tick();
    resetn = 1'b1;
    #1;
    checks++;
    if ({mem_err, stall_cnt, flush_cnt, wait_cnt} !== {1'b0, 12'd0})
    begin errors++; $display("FAIL reset_state got err=%b st=%0d fl=%0d wt=%0d exp all 0", mem_err, stall_cnt, flush_cnt, wait_cnt); end
    checks++;
    if (ctl !== C_NORMAL) begin errors++; $display("FAIL reset_release_ctl got=%b exp=%b", ctl, C_NORMAL); end
  endtask

  task automatic test_load_use();
    do_reset();
    set_hazard(5'd5);
    #1;
    checks++;
    if (ctl !== C_LDUSE) begin errors++; $display("FAIL lu_rs_ctl got=%b exp=%b", ctl, C_LDUSE); end
    tick();
    idle();
    #1;
    checks++;
    if (stall_cnt !== 4'd1) begin errors++; $display("FAIL lu_stall_cnt got=%0d exp=1", stall_cnt); end
    checks++;
    if (ctl !== C_NORMAL) begin errors++; $display("FAIL lu_after_ctl got=%b exp=%b", ctl, C_NORMAL); end
    // Destination r0 never creates a hazard
    set_hazard(5'd0);
    id_rs = 5'd0;
    #1;
    checks++;
    if (ctl !== C_NORMAL) begin errors++; $display("FAIL lu_r0_ctl got=%b exp=%b", ctl, C_NORMAL); end
    tick();
    checks++;
    if (stall_cnt !== 4'd1) begin errors++; $display("FAIL lu_r0_cnt got=%0d exp=1", stall_cnt); end
    // rt source, with and without uses_rt
    idle();
    ex_mem_read = 1'b1; ex_rd = 5'd7; id_rt = 5'd7; id_rs = 5'd7;
    #1;
    checks++;
    if (ctl !== C_NORMAL) begin errors++; $display("FAIL lu_unused_ctl got=%b exp=%b", ctl, C_NORMAL); end
    id_uses_rt = 1'b1;
    #1;
    checks++;
    if (ctl !== C_LDUSE) begin errors++; $display("FAIL lu_rt_ctl got=%b exp=%b", ctl, C_LDUSE); end
    tick();
    ex_mem_read = 1'b0;
    #1;
    checks++;
    if (ctl !== C_NORMAL) begin errors++; $display("FAIL lu_noload_ctl got=%b exp=%b", ctl, C_NORMAL); end
    checks++;
    if (stall_cnt !== 4'd2) begin errors++; $display("FAIL lu_rt_cnt got=%0d exp=2", stall_cnt); end
    idle();
  endtask

  task automatic test_branch();
    do_reset();
    set_hazard(5'd5);
    ex_branch_taken = 1'b1;
    #1;
    checks++;
    if (ctl !== C_BRANCH) begin errors++; $display("FAIL br_ctl got=%b exp=%b", ctl, C_BRANCH); end
    tick();
    idle();
    #1;
    checks++;
    if ({flush_cnt, stall_cnt} !== {4'd1, 4'd0})
    begin errors++; $display("FAIL br_cnts got fl=%0d st=%0d exp fl=1 st=0", flush_cnt, stall_cnt); end
  endtask

  task automatic test_mem_wait();
    do_reset();
    mem_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (ctl !== C_FREEZE) begin errors++; $display("FAIL wait_ctl cyc=%0d got=%b exp=%b", i, ctl, C_FREEZE); end
      tick();
    end
    mem_ready = 1'b1;
    #1;
    checks++;
    if (ctl !== C_NORMAL) begin errors++; $display("FAIL wait_done_ctl got=%b exp=%b", ctl, C_NORMAL); end
    tick();
    checks++;
    if ({wait_cnt, mem_err} !== {4'd3, 1'b0})
    begin errors++; $display("FAIL wait_cnt got=%0d err=%b exp=3 err=0", wait_cnt, mem_err); end
    // Single-cycle access: no freeze, no count
    #1;
    checks++;
    if (ctl !== C_NORMAL) begin errors++; $display("FAIL single_ctl got=%b exp=%b", ctl, C_NORMAL); end
    tick();
    mem_req = 1'b0; mem_ready = 1'b0;
    #1;
    checks++;
    if ({ctl, wait_cnt} !== {C_NORMAL, 4'd3})
    begin errors++; $display("FAIL single_after got ctl=%b wt=%0d exp ctl=%b wt=3", ctl, wait_cnt, C_NORMAL); end
  endtask

  task automatic test_branch_during_wait();
    do_reset();
    mem_req = 1'b1;
    ex_branch_taken = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (ctl !== C_FREEZE) begin errors++; $display("FAIL bw_freeze cyc=%0d got=%b exp=%b", i, ctl, C_FREEZE); end
      tick();
    end
    checks++;
    if (flush_cnt !== 4'd0) begin errors++; $display("FAIL bw_flush_held got=%0d exp=0", flush_cnt); end
    mem_ready = 1'b1;
    #1;
    checks++;
    if (ctl !== C_BRANCH) begin errors++; $display("FAIL bw_release_ctl got=%b exp=%b", ctl, C_BRANCH); end
    tick();
    idle();
    #1;
    checks++;
    if ({flush_cnt, wait_cnt} !== {4'd1, 4'd2})
    begin errors++; $display("FAIL bw_cnts got fl=%0d wt=%0d exp fl=1 wt=2", flush_cnt, wait_cnt); end
  endtask

  task automatic test_timeout();
    do_reset();
    mem_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if ({ctl, mem_err} !== {C_FREEZE, 1'b0})
      begin errors++; $display("FAIL to_frozen cyc=%0d got ctl=%b err=%b exp ctl=%b err=0", i, ctl, mem_err, C_FREEZE); end
      tick();
    end
    checks++;
    if (mem_err !== 1'b1) begin errors++; $display("FAIL to_err got=%b exp=1", mem_err); end
    // ERR is terminal: ready does not release it
    mem_ready = 1'b1;
    ex_branch_taken = 1'b1;
    tick();
    tick();
    checks++;
    if ({ctl, mem_err, flush_cnt} !== {C_FREEZE, 1'b1, 4'd0})
    begin errors++; $display("FAIL to_sticky got ctl=%b err=%b fl=%0d exp ctl=%b err=1 fl=0", ctl, mem_err, flush_cnt, C_FREEZE); end
    checks++;
    if (wait_cnt !== 4'd5) begin errors++; $display("FAIL to_wait_cnt got=%0d exp=5", wait_cnt); end
    idle();
    resetn = 1'b0;
    #1;
    checks++;
    if (ctl !== C_RESET) begin errors++; $display("FAIL to_reset_ctl got=%b exp=%b", ctl, C_RESET); end
    tick();
    resetn = 1'b1;
    #1;
    checks++;
    if ({ctl, mem_err, stall_cnt, flush_cnt, wait_cnt} !== {C_NORMAL, 1'b0, 12'd0})
    begin errors++; $display("FAIL to_after_reset got ctl=%b err=%b wt=%0d exp ctl=%b err=0 wt=0", ctl, mem_err, wait_cnt, C_NORMAL); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_hazard(5'd5);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 14) begin
        checks++;
        if (stall_cnt !== 4'd15) begin errors++; $display("FAIL sat_reach got=%0d exp=15", stall_cnt); end
      end
    end
    checks++;
    if (stall_cnt !== 4'd15) begin errors++; $display("FAIL sat_hold got=%0d exp=15", stall_cnt); end
    idle();
  endtask

  initial begin
    idle();
    resetn = 1'b0;
    test_reset();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_branch_during_wait();
    test_timeout();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central stall/flush controller for the 5-stage pipeline. It sits beside the PC and the four pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and drives their write-enable, hold and clear inputs. It resolves load-use hazards, taken-branch squashes in EX and multi-cycle data-memory waits, including a timeout. It also keeps saturating event counters for the performance report.

## Interface
- `MEM_TIMEOUT`, default 64: maximum consecutive wait cycles before a memory error is declared.
- `CNT_W`, default 16: width of each event counter.
- `clk`  in  1  clock; all state updates on the rising edge.
- `resetn`  in  1  reset, synchronous, active-low.
- `id_rs`, `id_rt`  in  5 each  source registers of the instruction in ID.
- `id_uses_rs`, `id_uses_rt`  in  1 each  the ID instruction actually reads that source.
- `ex_rd`  in  5  destination register of the instruction in EX.
- `ex_mem_read`  in  1  the EX instruction is a load.
- `ex_branch_taken`  in  1  a branch resolved taken in EX this cycle.
- `mem_req`  in  1  the MEM stage is accessing data memory this cycle.
- `mem_ready`  in  1  data memory completes the access this cycle.
- `pc_we`  out  1  PC register load enable.
- `ifid_hold`  out  1  IF/ID register keeps its contents.
- `ifid_flush`  out  1  IF/ID register loads zeros (bubble).
- `idex_hold`, `idex_flush`  out  1 each  the same controls for ID/EX.
- `exmem_hold`  out  1  EX/MEM register keeps its contents.
- `memwb_flush`  out  1  MEM/WB register loads a bubble.
- `mem_err`  out  1  sticky timeout flag.
- `stall_cnt`, `flush_cnt`, `wait_cnt`  out  `CNT_W` each  event counters.

## Operation
- FSM states:
  - RUN (reset state).
  - WAIT: a memory access is outstanding.
  - ERR: the memory timed out; terminal until reset.
- State transitions:
  - RUN → WAIT when `mem_req` is 1 and `mem_ready` is 0.
  - WAIT → RUN when `mem_ready` is 1.
  - WAIT → ERR when the wait counter reaches `MEM_TIMEOUT` with `mem_ready` still 0.
  - ERR persists until `resetn` is 0.
- `freeze` = (`mem_req` & !`mem_ready`) | state is ERR. It is evaluated in every state, so the first wait cycle in RUN also freezes.
- `load_use` = `ex_mem_read` & (`ex_rd` ≠ 0) & ((`id_uses_rs` & `id_rs` == `ex_rd`) | (`id_uses_rt` & `id_rt` == `ex_rd`)).
- Priority is ERR/freeze > branch > load-use. Lower-priority events are ignored that cycle and re-evaluated on the next one.
- Freeze cycle:
  - `pc_we` = 0.
  - `ifid_hold`, `idex_hold`, `exmem_hold` = 1.
  - `memwb_flush` = 1.
  - All other flushes = 0.
- Branch cycle (no freeze):
  - `pc_we` = 1.
  - `ifid_flush` and `idex_flush` = 1.
  - All holds = 0.
- Load-use cycle (no freeze, no branch):
  - `pc_we` = 0.
  - `ifid_hold` = 1.
  - `idex_flush` = 1.
- Normal cycle: `pc_we` = 1 and every hold and flush = 0.
- A hold and a flush are never both asserted for the same register.
- Counters saturate at all-ones:
  - `stall_cnt` increments on each load-use cycle that actually takes effect.
  - `flush_cnt` increments on each branch flush.
  - `wait_cnt` increments on each freeze cycle caused by `mem_req` (not ERR).
- Internal wait counter is `$clog2(MEM_TIMEOUT+1)` bits. It clears on entering WAIT and counts WAIT cycles.
- `mem_err` = 1 exactly while the FSM is in ERR.

## Timing
- All control outputs are combinational from the current state and inputs, and act at the same clock edge.
- FSM, counters and `mem_err` update on the rising edge of `clk`.
- Reset (`resetn` = 0 sampled at an edge):
  - State → RUN; all counters → 0; `mem_err` → 0.
  - While `resetn` is 0, outputs are forced: `pc_we` = 0, all holds = 0, all flushes = 1.
- Reset during WAIT or ERR aborts the wait immediately; the next cycle after release is a normal RUN cycle.
- A load-use hazard produces exactly one bubble. The next cycle, the load has moved to MEM and `load_use` drops unless a new hazard arises.
- A single-cycle memory access (`mem_req` and `mem_ready` both 1) causes no freeze and no state change.
- ERR is entered on the edge where the wait counter equals `MEM_TIMEOUT`. That is `MEM_TIMEOUT`+1 frozen cycles including the first RUN-detected cycle.

## Structure
- A shared package `pipe_ctrl_pkg` holds:
  - The FSM state encoding (RUN = 0, WAIT = 1, ERR = 2, 2 bits).
  - Register number 0 as the constant `REG_ZERO`.
- One sub-module: `sat_counter`, parameterized by width, with inputs `inc` and `clr` and saturating behaviour. It is instantiated three times for the event counters.
- Hazard detection stays in the top module as combinational logic.

## Test plan
- Load-use hazard: `ex_mem_read`=1, `ex_rd`=5, `id_rs`=5, `id_uses_rs`=1 for one cycle → `pc_we`=0, `ifid_hold`=1, `idex_flush`=1; `stall_cnt` reads 1 afterwards. Repeat with `ex_rd`=0 → no stall.
- Taken branch: `ex_branch_taken`=1 in the same cycle as a load-use hazard → `ifid_flush`=1, `idex_flush`=1, `pc_we`=1; `flush_cnt`=1 and `stall_cnt` stays 0.
- Memory wait: `mem_req`=1 with `mem_ready` held 0 for 3 cycles, then 1 → 3 freeze cycles with `memwb_flush`=1 and all holds 1; FSM back in RUN; `wait_cnt`=3.
- Timeout: `MEM_TIMEOUT`=4, `mem_ready` never asserted → `mem_err`=1 after 5 frozen cycles and remains 1; pulse `resetn` low → `mem_err`=0, counters 0, state RUN.
- Branch during wait: `ex_branch_taken`=1 while frozen → no flushes and `flush_cnt` unchanged; the branch takes effect on the cycle `mem_ready`=1.
- Saturation: `CNT_W`=4 with 20 load-use cycles → `stall_cnt`=15.
